// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the selects through I0..I3, samples Y per channel, emits a snapshot.
// Optional build macro MUX_SCAN_CONT_EN lets a held start chain scans straight from DONE.
module mux4_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       Y,
  output logic       S1,
  output logic       S0,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       valid
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       shadow_q;
  logic [3:0]       shadow_d;
  logic [3:0]       result_q;
  logic             valid_q;
  logic             done_q;
  logic             dwell_end;

  assign dwell_end = (cnt_q == LAST_CNT);

  // Shadow with the current channel's sample merged in, so the final capture reaches result on the same edge.
  always_comb begin
    shadow_d        = shadow_q;
    shadow_d[sel_q] = Y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= 2'b00;
      cnt_q    <= '0;
      shadow_q <= 4'b0000;
      result_q <= 4'b0000;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          sel_q  <= 2'b00;
          cnt_q  <= '0;
          if (start && !abort) begin
            state_q <= SCAN;
            valid_q <= 1'b0;
          end
        end
        SCAN: begin
          if (abort) begin
            state_q  <= IDLE;
            sel_q    <= 2'b00;
            cnt_q    <= '0;
            shadow_q <= 4'b0000;
          end else if (dwell_end) begin
            shadow_q <= shadow_d;
            cnt_q    <= '0;
            if (sel_q == 2'd3) begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              result_q <= shadow_d;
              valid_q  <= 1'b1;
            end else begin
              sel_q <= sel_q + 2'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          done_q <= 1'b0;
          cnt_q  <= '0;
          sel_q  <= 2'b00;
`ifdef MUX_SCAN_CONT_EN
          if (start && !abort) begin
            state_q <= SCAN;
            valid_q <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= 2'b00;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign S1     = sel_q[1];
  assign S0     = sel_q[0];
  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign valid  = valid_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Self-checking bench for mux4_scan_ctrl: behavioural 4:1 mux on Y, scoreboard of expected snapshots.
module tb_mux4_scan_ctrl;

  localparam int DWELL = 4;
  localparam int SCAN_CYC = 4 * DWELL;
`ifdef MUX_SCAN_CONT_EN
  localparam int B2B_PERIOD = SCAN_CYC + 1;
`else
  localparam int B2B_PERIOD = SCAN_CYC + 2;
`endif

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       Y, S1, S0, busy, done, valid;
  logic [3:0] result;
  logic       Y1, S1b, S0b, busy1, done1, valid1;
  logic [3:0] result1;
  logic [3:0] in_v;

  int         checks = 0;
  int         failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_result = 4'b0000;

  always #5 clk = ~clk;

  assign Y  = in_v[{S1, S0}];
  assign Y1 = in_v[{S1b, S0b}];

  mux4_scan_ctrl #(.DWELL(DWELL), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Y(Y),
    .S1(S1), .S0(S0), .busy(busy), .done(done), .result(result), .valid(valid)
  );

  mux4_scan_ctrl #(.DWELL(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .Y(Y1),
    .S1(S1b), .S0(S0b), .busy(busy1), .done(done1), .result(result1), .valid(valid1)
  );

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_v = 4'b0000;
    repeat (2) @(negedge clk);
    checks++;
    if ({S1, S0} !== 2'b00) begin
      failures++; $display("FAIL reset_sel got %b want 00", {S1, S0});
    end
    checks++;
    if ({busy, done, valid} !== 3'b000) begin
      failures++; $display("FAIL reset_flags busy/done/valid got %b want 000", {busy, done, valid});
    end
    checks++;
    if (result !== 4'b0000) begin
      failures++; $display("FAIL reset_result got %b want 0000", result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_and_check(input string name);
    logic [3:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++; $display("FAIL %s scoreboard empty, result got %b", name, result);
    end else begin
      exp = exp_q.pop_front();
      if (result !== exp || valid !== 1'b1) begin
        failures++;
        $display("FAIL %s result got %b valid %b want %b valid 1", name, result, valid, exp);
      end
      last_result = exp;
    end
  endtask

  task automatic test_scan(input logic [3:0] pattern);
    int sel_err = 0;
    in_v = pattern;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(pattern);
    for (int k = 1; k <= SCAN_CYC; k++) begin
      @(negedge clk);
      if (k < SCAN_CYC) begin
        checks++;
        if ({S1, S0} !== 2'(k / DWELL) || done !== 1'b0 || busy !== 1'b1) begin
          failures++; sel_err++;
          if (sel_err < 4)
            $display("FAIL scan_step k=%0d sel got %b want %b done %b busy %b",
                     k, {S1, S0}, 2'(k / DWELL), done, busy);
        end
      end else begin
        checks++;
        if (done !== 1'b1) begin
          failures++; $display("FAIL scan_done_time done got %b want 1 at cycle %0d", done, k);
        end
        pop_and_check("scan_result");
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || {S1, S0} !== 2'b00 || valid !== 1'b1) begin
      failures++;
      $display("FAIL scan_after done %b busy %b sel %b valid %b want 0 0 00 1", done, busy, {S1, S0}, valid);
    end
  endtask

  task automatic test_abort();
    int dcount = 0;
    in_v = 4'b0110;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || {S1, S0} !== 2'b00 || valid !== 1'b0) begin
      failures++; $display("FAIL abort_state busy %b sel %b valid %b want 0 00 0", busy, {S1, S0}, valid);
    end
    checks++;
    if (result !== last_result) begin
      failures++; $display("FAIL abort_result got %b want %b", result, last_result);
    end
    repeat (SCAN_CYC + 4) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    checks++;
    if (dcount != 0) begin
      failures++; $display("FAIL abort_no_done got %0d done pulses want 0", dcount);
    end
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL abort_wins_idle busy got %b want 0", busy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_restart_ignored();
    int k;
    in_v = 4'b0011;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(4'b0011);
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == 5) ? 1'b1 : 1'b0;
      if (done === 1'b1) break;
    end
    start = 1'b0;
    checks++;
    if (k != SCAN_CYC) begin
      failures++; $display("FAIL restart_done_time got %0d cycles want %0d", k, SCAN_CYC);
    end
    pop_and_check("restart_result");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    in_v = 4'b1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({S1, S0, busy, done, valid} !== 5'b00000 || result !== 4'b0000) begin
      failures++;
      $display("FAIL midreset_outputs sel %b busy %b done %b valid %b result %b want all 0",
               {S1, S0}, busy, done, valid, result);
    end
    last_result = 4'b0000;
    @(negedge clk);
    test_scan(4'b0101);
  endtask

  task automatic test_dwell1();
    int k;
    in_v = 4'b1001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(4'b1001);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (done1 !== ((j == 4) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL dwell1_done cycle %0d got %b want %b", j, done1, (j == 4));
      end
    end
    checks++;
    if (result1 !== 4'b1001 || valid1 !== 1'b1) begin
      failures++; $display("FAIL dwell1_result got %b valid %b want 1001 valid 1", result1, valid1);
    end
    for (k = 5; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    checks++;
    if (k != SCAN_CYC) begin
      failures++; $display("FAIL dwell1_main_time got %0d want %0d", k, SCAN_CYC);
    end
    pop_and_check("dwell1_main_result");
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    int n;
    in_v = 4'b1010;
    start = 1'b1;
    @(negedge clk);
    exp_q.push_back(4'b1010);
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    checks++;
    if (k != SCAN_CYC) begin
      failures++; $display("FAIL b2b_first_time got %0d want %0d", k, SCAN_CYC);
    end
    pop_and_check("b2b_first_result");
    in_v[3] = 1'b0;
    exp_q.push_back(4'b0010);
    for (n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    checks++;
    if (n != B2B_PERIOD) begin
      failures++; $display("FAIL b2b_period got %0d want %0d", n, B2B_PERIOD);
    end
    pop_and_check("b2b_second_result");
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL b2b_idle busy got %b want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_scan(4'b1010);
    test_abort();
    test_restart_ignored();
    test_reset_mid();
    test_dwell1();
    test_back_to_back();
    test_scan(4'b0110);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
